// File: rtl/cpu_pkg.sv
// Shared opcode constants, instruction field positions and FSM encoding for instr_sequencer.
// Optional shift opcodes are enabled with INSTR_SEQ_SHIFT_EN.
package cpu_pkg;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RD_HI  = 11;
  localparam int RD_LO  = 9;
  localparam int RS_HI  = 8;
  localparam int RS_LO  = 6;
  localparam int RT_HI  = 5;
  localparam int RT_LO  = 3;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_e;

  // Opcodes that produce a register write through WB.
  function automatic logic op_writes(input logic [3:0] op);
    logic w;
    w = (op >= OP_ADD) && (op <= OP_MOV);
`ifdef INSTR_SEQ_SHIFT_EN
    w = w || (op == OP_SHL) || (op == OP_SHR);
`endif
    return w;
  endfunction

endpackage

// File: rtl/alu8.sv
// Combinational 8-bit ALU for instr_sequencer; carry is borrow for SUB.
// SHL/SHR exist only with INSTR_SEQ_SHIFT_EN.
module alu8
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm8,
  output logic [7:0] result,
  output logic       carry
);

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (opcode)
      OP_ADD: {carry, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        carry  = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm8;
      OP_MOV: result = a;
`ifdef INSTR_SEQ_SHIFT_EN
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
`endif
      default: begin
        result = 8'h00;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB instruction sequencer driving an external register file.
// Define INSTR_SEQ_SHIFT_EN to enable SHL (0x9) / SHR (0xA).
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic [7:0]  pc,
  output logic [2:0]  rs,
  output logic [2:0]  rt,
  input  logic [7:0]  read_data1,
  input  logic [7:0]  read_data2,
  output logic [2:0]  rd,
  output logic        reg_write,
  output logic [7:0]  write_data,
  output logic        zero,
  output logic        carry,
  output logic        halted,
  output logic        illegal
);

  state_e      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  result_q, result_d;
  logic        res_carry_q, res_carry_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic        halted_q, halted_d;
  logic        illegal_q, illegal_d;

  logic [3:0]  op;
  logic [7:0]  alu_result;
  logic        alu_carry;

  assign op = ir_q[OP_HI:OP_LO];

  alu8 u_alu (
    .opcode (op),
    .a      (a_q),
    .b      (b_q),
    .imm8   (ir_q[IMM_HI:IMM_LO]),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    res_carry_d = res_carry_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    halted_d    = halted_q;
    illegal_d   = illegal_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          pc_d    = pc_q + 8'd1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = read_data1;
        b_d     = read_data2;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // The ALU carry is parked until WB so flags only move on a write.
        if (op_writes(op)) begin
          result_d    = alu_result;
          res_carry_d = alu_carry;
          state_d     = S_WB;
        end else if (op == OP_NOP) begin
          state_d = S_FETCH;
        end else if (op == OP_HALT) begin
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        zero_d  = (result_q == 8'h00);
        carry_d = res_carry_q;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      pc_q        <= 8'h00;
      ir_q        <= 16'h0000;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      result_q    <= 8'h00;
      res_carry_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      res_carry_q <= res_carry_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      halted_q    <= halted_d;
      illegal_q   <= illegal_d;
    end
  end

  // Gated by reset_n so a reset landing mid-WB cannot commit the write.
  assign instr_ready = reset_n && (state_q == S_FETCH);
  assign reg_write   = reset_n && (state_q == S_WB);
  assign pc          = pc_q;
  assign rs          = ir_q[RS_HI:RS_LO];
  assign rt          = ir_q[RT_HI:RT_LO];
  assign rd          = ir_q[RD_HI:RD_LO];
  assign write_data  = result_q;
  assign zero        = zero_q;
  assign carry       = carry_q;
  assign halted      = halted_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: random and directed programs against an
// architectural model (register array + flags), with an attached register file.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [7:0]  pc;
  logic [2:0]  rs, rt, rd;
  logic [7:0]  read_data1, read_data2;
  logic        reg_write;
  logic [7:0]  write_data;
  logic        zero, carry, halted, illegal;

  int total = 0;
  int bad   = 0;

  // Register file attached to the DUT.
  logic [7:0] rf [8];
  // Architectural model state.
  logic [7:0] mrf [8];
  logic [7:0] mpc;
  logic       mz, mc, mill;
  logic [7:0] last_wd;

  instr_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .pc          (pc),
    .rs          (rs),
    .rt          (rt),
    .read_data1  (read_data1),
    .read_data2  (read_data2),
    .rd          (rd),
    .reg_write   (reg_write),
    .write_data  (write_data),
    .zero        (zero),
    .carry       (carry),
    .halted      (halted),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  assign read_data1 = rf[rs];
  assign read_data2 = rf[rt];

  always @(posedge clk) if (reg_write) rf[rd] <= write_data;

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [2:0] d,
                                      input logic [2:0] s, input logic [2:0] t);
    return {op, d, s, t, 3'b000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] d, input logic [7:0] imm);
    return {4'h6, d, 1'b0, imm};
  endfunction

  task automatic model_reset();
    mpc = 8'h00; mz = 1'b0; mc = 1'b0; mill = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Issue one instruction from a FETCH negedge; returns at the next FETCH negedge.
  task automatic run_instr(input logic [15:0] w);
    logic [3:0] op; logic [2:0] d, s, t; logic [7:0] a, b, er;
    logic ew, ec;
    int sum, n, nw;
    logic [2:0] wrd; logic [7:0] wdat;
    op = w[15:12]; d = w[11:9]; s = w[8:6]; t = w[5:3];
    a = mrf[s]; b = mrf[t]; ew = 1'b1; ec = 1'b0; er = 8'h00;
    case (op)
      4'h1: begin sum = int'(a) + int'(b); er = sum[7:0]; ec = (sum > 255); end
      4'h2: begin sum = int'(a) - int'(b); er = sum[7:0]; ec = (sum < 0); end
      4'h3: er = a & b;
      4'h4: er = a | b;
      4'h5: er = a ^ b;
      4'h6: er = w[7:0];
      4'h7: er = a;
`ifdef INSTR_SEQ_SHIFT_EN
      4'h9: begin sum = int'(a) * 2; er = sum[7:0]; ec = a[7]; end
      4'hA: begin er = a / 8'd2; ec = a[0]; end
`endif
      default: ew = 1'b0;
    endcase
    if (ew) begin
      mrf[d] = er; mz = (er == 8'h00); mc = ec;
    end else if (op != 4'h0) begin
      mill = 1'b1;
    end
    mpc = mpc + 8'd1;

    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL ready_before_issue: got %b want 1", instr_ready);
    end
    instr_valid = 1'b1; instr = w;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 16'($urandom);
    n = 1; nw = 0; wrd = 3'd0; wdat = 8'h00;
    while (n < 8) begin
      @(negedge clk);
      if (instr_ready === 1'b1) break;
      n++;
      if (reg_write === 1'b1) begin nw++; wrd = rd; wdat = write_data; end
    end
    last_wd = wdat;
    total++;
    if (n != (ew ? 4 : 3)) begin
      bad++; $display("FAIL latency w=%h: got %0d want %0d", w, n, ew ? 4 : 3);
    end
    total++;
    if (nw != (ew ? 1 : 0)) begin
      bad++; $display("FAIL write_count w=%h: got %0d want %0d", w, nw, ew ? 1 : 0);
    end
    if (ew) begin
      total++;
      if (wrd !== d || wdat !== er) begin
        bad++; $display("FAIL write w=%h: got r%0d=%h want r%0d=%h", w, wrd, wdat, d, er);
      end
    end
    total++;
    if (zero !== mz || carry !== mc || illegal !== mill || pc !== mpc) begin
      bad++;
      $display("FAIL state w=%h: got z%b c%b ill%b pc%h want z%b c%b ill%b pc%h",
               w, zero, carry, illegal, pc, mz, mc, mill, mpc);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; instr_valid = 1'b1; instr = 16'h1234;
    @(negedge clk); @(negedge clk);
    total++;
    if (instr_ready !== 1'b0 || reg_write !== 1'b0 || pc !== 8'h00 || halted !== 1'b0 ||
        illegal !== 1'b0 || zero !== 1'b0 || carry !== 1'b0 || rs !== 3'd0 ||
        rt !== 3'd0 || rd !== 3'd0 || write_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: rdy%b we%b pc%h h%b ill%b z%b c%b rs%0d rt%0d rd%0d wd%h want all 0",
               instr_ready, reg_write, pc, halted, illegal, zero, carry, rs, rt, rd, write_data);
    end
    instr_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (instr_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_reset: got %b want 1", instr_ready);
    end
    model_reset();
  endtask

  task automatic test_directed();
    run_instr(ldi(3'd1, 8'h7F));
    run_instr(ldi(3'd2, 8'h01));
    run_instr(enc(4'h1, 3'd3, 3'd1, 3'd2));
    total++;
    if (last_wd !== 8'h80 || carry !== 1'b0 || zero !== 1'b0) begin
      bad++; $display("FAIL add_7f_01: got wd=%h c%b z%b want 80 c0 z0", last_wd, carry, zero);
    end
    run_instr(ldi(3'd1, 8'hFF));
    run_instr(enc(4'h1, 3'd4, 3'd1, 3'd2));
    total++;
    if (last_wd !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
      bad++; $display("FAIL add_ff_01: got wd=%h c%b z%b want 00 c1 z1", last_wd, carry, zero);
    end
    run_instr(ldi(3'd1, 8'h05));
    run_instr(ldi(3'd2, 8'h06));
    run_instr(enc(4'h2, 3'd5, 3'd1, 3'd2));
    total++;
    if (last_wd !== 8'hFF || carry !== 1'b1) begin
      bad++; $display("FAIL sub_05_06: got wd=%h c%b want ff c1", last_wd, carry);
    end
    // rd aliasing a source and writes to r0.
    run_instr(enc(4'h1, 3'd1, 3'd1, 3'd1));
    run_instr(ldi(3'd0, 8'h3C));
    run_instr(enc(4'h7, 3'd6, 3'd0, 3'd0));
  endtask

  task automatic test_idle();
    logic [7:0] pc0;
    int errs;
    pc0 = pc; errs = 0;
    instr_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (instr_ready !== 1'b1 || pc !== pc0 || reg_write !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL idle: got %0d bad cycles want 0 (pc %h vs %h)", errs, pc, pc0);
    end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int i = 0; i < 80; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'h8) op = 4'h1;
      run_instr({op, 12'($urandom)});
    end
  endtask

  task automatic test_shift();
    run_instr(ldi(3'd4, 8'h81));
    run_instr(enc(4'h9, 3'd5, 3'd4, 3'd0));
`ifdef INSTR_SEQ_SHIFT_EN
    total++;
    if (last_wd !== 8'h02 || carry !== 1'b1) begin
      bad++; $display("FAIL shl_81: got wd=%h c%b want 02 c1", last_wd, carry);
    end
`else
    total++;
    if (illegal !== 1'b1) begin
      bad++; $display("FAIL shl_disabled: got illegal=%b want 1", illegal);
    end
`endif
  endtask

  task automatic test_illegal_halt();
    logic [7:0] pc0;
    int errs;
    do_reset();
    run_instr(16'hF123);
    total++;
    if (illegal !== 1'b1) begin
      bad++; $display("FAIL illegal_f: got %b want 1", illegal);
    end
    instr_valid = 1'b1; instr = enc(4'h8, 3'd0, 3'd0, 3'd0);
    @(posedge clk); #1;
    instr = enc(4'h6, 3'd1, 3'd0, 3'd0);
    pc0 = mpc + 8'd1;
    repeat (3) @(negedge clk);
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      if (halted !== 1'b1 || instr_ready !== 1'b0 || reg_write !== 1'b0 || pc !== pc0) errs++;
      @(negedge clk);
    end
    total++;
    if (errs != 0) begin
      bad++; $display("FAIL halt_terminal: got %0d bad cycles want 0 (h%b rdy%b pc%h)",
                      errs, halted, instr_ready, pc);
    end
    instr_valid = 1'b0;
    do_reset();
    total++;
    if (halted !== 1'b0 || illegal !== 1'b0 || instr_ready !== 1'b1) begin
      bad++; $display("FAIL halt_cleared: got h%b ill%b rdy%b want 0 0 1", halted, illegal, instr_ready);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    for (int i = 0; i < 256; i++) run_instr(16'h0000);
    total++;
    if (pc !== 8'h00) begin
      bad++; $display("FAIL pc_wrap: got %h want 00", pc);
    end
  endtask

  task automatic test_reset_wb();
    logic [7:0] old7;
    int n;
    run_instr(ldi(3'd1, 8'h11));
    run_instr(ldi(3'd2, 8'h22));
    old7 = rf[7];
    instr_valid = 1'b1; instr = enc(4'h1, 3'd7, 3'd1, 3'd2);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (n < 6 && reg_write !== 1'b1) begin @(negedge clk); n++; end
    total++;
    if (reg_write !== 1'b1) begin
      bad++; $display("FAIL reach_wb: got reg_write=%b want 1", reg_write);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (reg_write !== 1'b0) begin
      bad++; $display("FAIL wb_abort_we: got %b want 0", reg_write);
    end
    @(negedge clk);
    total++;
    if (rf[7] !== old7 || pc !== 8'h00 || instr_ready !== 1'b0) begin
      bad++; $display("FAIL wb_abort: got r7=%h pc=%h rdy=%b want %h 00 0", rf[7], pc, instr_ready, old7);
    end
    reset_n = 1'b1;
    @(negedge clk);
    model_reset();
    total++;
    if (instr_ready !== 1'b1 || pc !== 8'h00) begin
      bad++; $display("FAIL wb_abort_fetch: got rdy=%b pc=%h want 1 00", instr_ready, pc);
    end
    run_instr(enc(4'h7, 3'd3, 3'd7, 3'd0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin rf[i] = 8'h00; mrf[i] = 8'h00; end
    model_reset();
    last_wd = 8'h00;
    reset_n = 1'b0; instr_valid = 1'b0; instr = 16'h0000;
    test_reset();
    test_directed();
    test_idle();
    test_random();
    test_shift();
    test_illegal_halt();
    test_pc_wrap();
    test_reset_wb();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as listed below.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  synchronous active-low reset, sampled on clk.
REQ-004 instr_valid  input  1  upstream holds a valid instruction on instr.
REQ-005 instr  input  16  instruction word: [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt, [7:0] imm8.
REQ-006 instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-007 pc  output  8  address of the next instruction to fetch.
REQ-008 rs, rt  output  3 each  register-file read selects.
REQ-009 read_data1, read_data2  input  8 each  combinational register-file read data for rs and rt.
REQ-010 rd  output  3  register-file write select.
REQ-011 reg_write  output  1  register-file write enable.
REQ-012 write_data  output  8  register-file write data.
REQ-013 zero, carry  output  1 each  ALU flags.
REQ-014 halted  output  1  sticky HALT indication.
REQ-015 illegal  output  1  sticky illegal-opcode indication.

Function
REQ-016 The FSM SHALL have states FETCH, DECODE, EXEC, WB and HALT.
REQ-017 FETCH: instr_ready=1; on instr_valid&&instr_ready the block SHALL latch instr into IR, increment pc by 1 modulo 256 (0xFF wraps to 0x00), and go to DECODE; otherwise it stays in FETCH.
REQ-018 instr_ready SHALL be 1 only in FETCH and never in any other state.
REQ-019 DECODE: the block SHALL drive rs=IR[8:6] and rt=IR[5:3], capture read_data1/read_data2 into operand registers A/B at the cycle end, and go to EXEC.
REQ-020 EXEC: the block SHALL compute the result into a result register (ADD=0x1, SUB=0x2, AND=0x3, OR=0x4, XOR=0x5, LDI=0x6 result=imm8, MOV=0x7 result=A) and go to WB for opcodes 0x1-0x7.
REQ-021 EXEC with NOP (0x0) SHALL go to FETCH with no write.
REQ-022 EXEC with HALT (0x8) SHALL go to HALT.
REQ-023 EXEC with an illegal opcode SHALL set illegal=1 and go to FETCH with no write.
REQ-024 WB: reg_write=1 for exactly one cycle with rd=IR[11:9] and write_data=result, then the FSM goes to FETCH; reg_write SHALL be 0 in every other state.
REQ-025 Arithmetic SHALL be 8-bit wrapping.
REQ-026 ADD carry SHALL be the bit-8 carry-out; SUB carry SHALL be 1 when A<B unsigned (borrow).
REQ-027 AND/OR/XOR/MOV/LDI SHALL clear carry.
REQ-028 zero SHALL be (result==0); flags SHALL update only in WB and hold otherwise.
REQ-029 rd equal to rs or rt SHALL be legal; operands are already captured, so the write never affects the current instruction.
REQ-030 Writes to every register 0-7 SHALL be permitted; there is no hardwired zero register.
REQ-031 HALT SHALL be terminal: halted=1, instr_ready=0, reg_write=0, pc frozen until reset.
REQ-032 Minimum latency SHALL be 4 cycles per writing instruction (FETCH handshake, DECODE, EXEC, WB) and 3 cycles for NOP or illegal.

Reset
REQ-033 With reset_n=0 at a rising edge, the block SHALL go to FETCH and set pc=0, IR=0, A=B=0, result=0, rs=rt=rd=0, write_data=0, reg_write=0, zero=0, carry=0, halted=0, illegal=0.
REQ-034 instr_ready SHALL be 0 while reset_n=0 and 1 in the first cycle after release.
REQ-035 Reset asserted in any state, including mid-WB or HALT, SHALL abort the instruction with no register write on that edge.

Configuration
REQ-036 The macro INSTR_SEQ_SHIFT_EN, when defined, SHALL enable opcode 0x9 SHL (result=A<<1, carry=A[7]) and 0xA SHR (result=A>>1 logical, carry=A[0]), both writing via WB.
REQ-037 Without INSTR_SEQ_SHIFT_EN, opcodes 0x9 and 0xA SHALL be treated as illegal per REQ-023.

Structure
REQ-038 Opcode constants, instruction field bit positions and the FSM state encoding SHALL live in a shared package cpu_pkg.
REQ-039 The ALU SHALL be a separate combinational sub-module alu8 (inputs opcode, A, B, imm8; outputs result, carry), instantiated once.

Verification
REQ-040 Reset, then LDI r1,0x7F; LDI r2,0x01; ADD r3,r1,r2 -> WB writes r3=0x80 with carry=0, zero=0.
REQ-041 ADD of 0xFF+0x01 -> write_data=0x00, carry=1, zero=1; SUB of 0x05-0x06 -> write_data=0xFF, carry=1.
REQ-042 instr_valid held low for 10 cycles in FETCH -> instr_ready stays 1, pc unchanged, reg_write=0 throughout.
REQ-043 Opcode 0xF -> illegal=1, no reg_write, next FETCH in 3 cycles; then HALT -> halted=1, instr_ready=0 forever until reset_n=0 clears both.
REQ-044 Run 256 NOPs from pc=0 -> pc wraps to 0x00; reset_n pulsed during WB of an ADD -> no write, pc=0, FSM in FETCH.
REQ-045 With INSTR_SEQ_SHIFT_EN, SHL with A=0x81 -> write_data=0x02, carry=1; without the macro, the same word -> illegal=1, no write.
